mem_stage_inst2: RTL and testbench
==================================

// Module: mem_stage_inst2
// PURPOSE
//  Lane-2 MEM stage of the dual-issue core. Consumes the lane-2 EX/MEM register fields and runs
//  the data-memory request/ack handshake. Raises stall_m while an access is outstanding.
//  Selects the write-back value and registers it into the lane-2 MEM/WB stage.
//  Also drives the MEM-stage forwarding value for the hazard unit.
// PARAMETERS
//  DATA_W      32  datapath width
//  PC_W        8   PC / PC+2 width
//  MADDR_W     8   data-memory word-address width
//  TIMEOUT     15  max wait cycles for dmem_ack before abort (>=1)
// PORTS
//  clk             in   1        clock, rising edge
//  reset           in   1        asynchronous, active-low
//  alu_out_m       in   DATA_W   EX/MEM ALU result (memory address for ld/st)
//  rd2_m           in   DATA_W   EX/MEM store data
//  dest_reg_m      in   5        destination register
//  pc_plus2_m      in   PC_W     link value
//  pc_m            in   PC_W     instruction PC
//  mem_read_en_m   in   1        load
//  mem_write_en_m  in   1        store
//  reg_write_en_m  in   1        writes register file
//  mem_to_reg_m    in   2        00 ALU, 01 mem data, 10 PC+2, 11 ALU
//  dmem_req        out  1        access request
//  dmem_we         out  1        1 = write
//  dmem_addr       out  MADDR_W  alu_out_m[MADDR_W-1:0]
//  dmem_wdata      out  DATA_W   rd2_m
//  dmem_rdata      in   DATA_W   read data, valid with dmem_ack
//  dmem_ack        in   1        access complete (may be same cycle as req)
//  stall_m         out  1        freeze EX/MEM and all upstream stages
//  fwd_valid_m     out  1        fwd_data_m usable (reg write, non-load, dest!=0)
//  fwd_data_m      out  DATA_W   ALU or PC+2 value of the instruction in MEM
//  result_w        out  DATA_W   MEM/WB write-back data
//  dest_reg_w      out  5        MEM/WB destination
//  reg_write_en_w  out  1        MEM/WB write enable
//  pc_w            out  PC_W     MEM/WB PC (debug/trace)
//  mem_err_w       out  1        access aborted (timeout or rd+wr both set)
// BEHAVIOUR
//  - Reset: all outputs 0; FSM IDLE; timeout counter 0. Reset mid-wait drops dmem_req immediately.
//  - access = mem_read_en_m | mem_write_en_m.
//  - dmem_we = mem_write_en_m. Both read and write set: perform write, result_w=0, reg_write_en_w=0,
//    mem_err_w=1.
//  - FSM IDLE: dmem_req = access.
//    - ack in the same cycle: complete, no stall.
//    - access without ack: stall_m=1 (combinational), go WAIT, counter := 1.
//  - FSM WAIT: dmem_req=1, stall_m=1, addr/data held stable (inputs frozen by stall_m).
//    - ack: complete, stall_m=0 that cycle, go IDLE.
//    - counter==TIMEOUT without ack: abort, stall_m=0, go IDLE; WB gets reg_write_en_w=0,
//      mem_err_w=1.
//    - otherwise counter++.
//  - MEM/WB capture on every edge where stall_m=0.
//    - result_w by mem_to_reg_m; code 01 takes dmem_rdata.
//    - Loads capture rdata only on ack.
//  - While stall_m=1: MEM/WB loads a bubble (reg_write_en_w=0, dest 0, mem_err_w=0).
//  - Latency: non-memory op 1 cycle to WB; load/store 1 + wait cycles.
//  - A late ack arriving in IDLE with no access pending is ignored.
//  - fwd_valid_m = reg_write_en_m & ~mem_read_en_m & (dest_reg_m!=0); combinational, no stall effect.
// STRUCTURE
//  - dual_issue_pkg: MemtoReg encodings (MTR_ALU/MEM/PC2), FSM state encodings (ST_IDLE, ST_WAIT),
//    default widths.
//  - Sub-module mem_wb_inst2_reg: MEM/WB register with load-enable and bubble insert.
//  - The FSM and result mux live in this module.
// TESTING
//  1 ALU op alu=0x1234, mtr=00, rd=5, rwe=1 -> next cycle result_w=0x1234, dest 5, no stall.
//  2 Load, ack same cycle, rdata=0xCAFEF00D -> stall_m never 1; result_w=0xCAFEF00D next edge.
//  3 Store addr=0x40, wdata=0x55, ack after 3 cycles -> req/we/addr stable;
//    stall_m=1 exactly 3 cycles; WB bubbles then rwe_w=0.
//  4 Load, no ack -> stall 15 cycles; abort; mem_err_w=1, reg_write_en_w=0; FSM IDLE.
//  5 Reset low during WAIT -> dmem_req, stall_m, all WB outputs 0 immediately;
//    clean op after release.
//  6 mtr=10, pc_plus2=0x22 -> result_w=0x22; fwd_valid_m=1, fwd_data_m=0x22 in MEM cycle.

Source files
------------

// File: rtl/dual_issue_pkg.sv
// rtl/dual_issue_pkg.sv - shared encodings and default widths for the dual-issue core
package dual_issue_pkg;

    localparam int DATA_W_DEF  = 32;
    localparam int PC_W_DEF    = 8;
    localparam int MADDR_W_DEF = 8;
    localparam int TIMEOUT_DEF = 15;
    localparam int REG_W       = 5;

    typedef enum logic [1:0] {
        MTR_ALU     = 2'b00,
        MTR_MEM     = 2'b01,
        MTR_PC2     = 2'b10,
        MTR_ALU_ALT = 2'b11
    } mtr_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } mem_state_e;

endpackage

// File: rtl/mem_wb_inst2_reg.sv
// rtl/mem_wb_inst2_reg.sv - lane-2 MEM/WB pipeline register with load-enable and bubble insert
module mem_wb_inst2_reg
    import dual_issue_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int PC_W   = PC_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_en_i,
    input  logic              bubble_i,
    input  logic [DATA_W-1:0] result_i,
    input  logic [REG_W-1:0]  dest_reg_i,
    input  logic              reg_write_en_i,
    input  logic [PC_W-1:0]   pc_i,
    input  logic              mem_err_i,
    output logic [DATA_W-1:0] result_o,
    output logic [REG_W-1:0]  dest_reg_o,
    output logic              reg_write_en_o,
    output logic [PC_W-1:0]   pc_o,
    output logic              mem_err_o
);

    logic [DATA_W-1:0] result_q;
    logic [REG_W-1:0]  dest_reg_q;
    logic              reg_write_en_q;
    logic [PC_W-1:0]   pc_q;
    logic              mem_err_q;

    // A bubble is fully zeroed so a stalled slot can never be mistaken for a write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            result_q       <= '0;
            dest_reg_q     <= '0;
            reg_write_en_q <= 1'b0;
            pc_q           <= '0;
            mem_err_q      <= 1'b0;
        end else if (bubble_i) begin
            result_q       <= '0;
            dest_reg_q     <= '0;
            reg_write_en_q <= 1'b0;
            pc_q           <= '0;
            mem_err_q      <= 1'b0;
        end else if (load_en_i) begin
            result_q       <= result_i;
            dest_reg_q     <= dest_reg_i;
            reg_write_en_q <= reg_write_en_i;
            pc_q           <= pc_i;
            mem_err_q      <= mem_err_i;
        end
    end

    assign result_o       = result_q;
    assign dest_reg_o     = dest_reg_q;
    assign reg_write_en_o = reg_write_en_q;
    assign pc_o           = pc_q;
    assign mem_err_o      = mem_err_q;

endmodule

// File: rtl/mem_stage_inst2.sv
// rtl/mem_stage_inst2.sv - lane-2 MEM stage: dmem handshake FSM, stall, WB mux, MEM forwarding
module mem_stage_inst2
    import dual_issue_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int PC_W    = PC_W_DEF,
    parameter int MADDR_W = MADDR_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [DATA_W-1:0]  alu_out_m,
    input  logic [DATA_W-1:0]  rd2_m,
    input  logic [4:0]         dest_reg_m,
    input  logic [PC_W-1:0]    pc_plus2_m,
    input  logic [PC_W-1:0]    pc_m,
    input  logic               mem_read_en_m,
    input  logic               mem_write_en_m,
    input  logic               reg_write_en_m,
    input  logic [1:0]         mem_to_reg_m,
    output logic               dmem_req,
    output logic               dmem_we,
    output logic [MADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0]  dmem_wdata,
    input  logic [DATA_W-1:0]  dmem_rdata,
    input  logic               dmem_ack,
    output logic               stall_m,
    output logic               fwd_valid_m,
    output logic [DATA_W-1:0]  fwd_data_m,
    output logic [DATA_W-1:0]  result_w,
    output logic [4:0]         dest_reg_w,
    output logic               reg_write_en_w,
    output logic [PC_W-1:0]    pc_w,
    output logic               mem_err_w
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    mem_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              access;
    logic              req_c, stall_c, abort_c, err_c;
    logic [DATA_W-1:0] pc2_ext, sel_val, fwd_val, wb_result_c;
    logic              wb_rwe_c;

    assign access  = mem_read_en_m | mem_write_en_m;
    assign pc2_ext = {{(DATA_W-PC_W){1'b0}}, pc_plus2_m};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The counter holds the number of cycles already spent waiting; an ack on the
    // TIMEOUT-th wait cycle still wins over the abort.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_c   = 1'b0;
        stall_c = 1'b0;
        abort_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (access) begin
                    req_c = 1'b1;
                    if (!dmem_ack) begin
                        stall_c = 1'b1;
                        state_d = ST_WAIT;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
            ST_WAIT: begin
                req_c = 1'b1;
                if (dmem_ack) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(TIMEOUT)) begin
                    abort_c = 1'b1;
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    stall_c = 1'b1;
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        sel_val = alu_out_m;
        fwd_val = alu_out_m;
        case (mtr_e'(mem_to_reg_m))
            MTR_MEM: sel_val = dmem_rdata;
            MTR_PC2: begin
                sel_val = pc2_ext;
                fwd_val = pc2_ext;
            end
            default: sel_val = alu_out_m;
        endcase
        // Read+write together is illegal: the write still goes out, but nothing is written back.
        err_c       = abort_c | (mem_read_en_m & mem_write_en_m);
        wb_result_c = err_c ? '0 : sel_val;
        wb_rwe_c    = reg_write_en_m & ~err_c;
    end

    assign dmem_req    = reset & req_c;
    assign dmem_we     = reset & mem_write_en_m;
    assign dmem_addr   = reset ? alu_out_m[MADDR_W-1:0] : '0;
    assign dmem_wdata  = reset ? rd2_m : '0;
    assign stall_m     = reset & stall_c;
    assign fwd_valid_m = reset & reg_write_en_m & ~mem_read_en_m & (dest_reg_m != 5'd0);
    assign fwd_data_m  = reset ? fwd_val : '0;

    mem_wb_inst2_reg #(
        .DATA_W (DATA_W),
        .PC_W   (PC_W)
    ) u_mem_wb (
        .clk            (clk),
        .reset          (reset),
        .load_en_i      (~stall_c),
        .bubble_i       (stall_c),
        .result_i       (wb_result_c),
        .dest_reg_i     (dest_reg_m),
        .reg_write_en_i (wb_rwe_c),
        .pc_i           (pc_m),
        .mem_err_i      (err_c),
        .result_o       (result_w),
        .dest_reg_o     (dest_reg_w),
        .reg_write_en_o (reg_write_en_w),
        .pc_o           (pc_w),
        .mem_err_o      (mem_err_w)
    );

endmodule

// File: tb/tb_mem_stage_inst2.sv
// tb/tb_mem_stage_inst2.sv - self-checking bench for mem_stage_inst2
module tb_mem_stage_inst2;

    localparam int DATA_W  = 32;
    localparam int PC_W    = 8;
    localparam int MADDR_W = 8;
    localparam int TIMEOUT = 15;

    logic               clk = 1'b0;
    logic               reset;
    logic [DATA_W-1:0]  alu_out_m, rd2_m, dmem_rdata;
    logic [4:0]         dest_reg_m;
    logic [PC_W-1:0]    pc_plus2_m, pc_m;
    logic               mem_read_en_m, mem_write_en_m, reg_write_en_m, dmem_ack;
    logic [1:0]         mem_to_reg_m;
    logic               dmem_req, dmem_we, stall_m, fwd_valid_m;
    logic [MADDR_W-1:0] dmem_addr;
    logic [DATA_W-1:0]  dmem_wdata, fwd_data_m, result_w;
    logic [4:0]         dest_reg_w;
    logic               reg_write_en_w, mem_err_w;
    logic [PC_W-1:0]    pc_w;

    always #5 clk = ~clk;

    mem_stage_inst2 #(
        .DATA_W(DATA_W), .PC_W(PC_W), .MADDR_W(MADDR_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset),
        .alu_out_m(alu_out_m), .rd2_m(rd2_m), .dest_reg_m(dest_reg_m),
        .pc_plus2_m(pc_plus2_m), .pc_m(pc_m),
        .mem_read_en_m(mem_read_en_m), .mem_write_en_m(mem_write_en_m),
        .reg_write_en_m(reg_write_en_m), .mem_to_reg_m(mem_to_reg_m),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .stall_m(stall_m), .fwd_valid_m(fwd_valid_m), .fwd_data_m(fwd_data_m),
        .result_w(result_w), .dest_reg_w(dest_reg_w), .reg_write_en_w(reg_write_en_w),
        .pc_w(pc_w), .mem_err_w(mem_err_w)
    );

    typedef struct {
        logic [31:0] alu;
        logic [31:0] rd2;
        logic [4:0]  dest;
        logic [7:0]  pc2;
        logic [7:0]  pc;
        logic        rd;
        logic        wr;
        logic        rwe;
        logic [1:0]  mtr;
    } ins_t;

    typedef struct {
        ins_t        ins;
        logic        ack;
        logic [31:0] rdata;
        logic [31:0] e_result;
        logic        e_rwe;
        logic        e_err;
        logic        e_fwd_v;
        logic [31:0] e_fwd_d;
    } vec_t;

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input ins_t i);
        alu_out_m      = i.alu;
        rd2_m          = i.rd2;
        dest_reg_m     = i.dest;
        pc_plus2_m     = i.pc2;
        pc_m           = i.pc;
        mem_read_en_m  = i.rd;
        mem_write_en_m = i.wr;
        reg_write_en_m = i.rwe;
        mem_to_reg_m   = i.mtr;
    endtask

    function automatic ins_t mk(input logic [31:0] alu, input logic [31:0] rd2, input logic [4:0] dest,
                                input logic [7:0] pc2, input logic [7:0] pc, input logic rd,
                                input logic wr, input logic rwe, input logic [1:0] mtr);
        ins_t i;
        i.alu = alu; i.rd2 = rd2; i.dest = dest; i.pc2 = pc2; i.pc = pc;
        i.rd = rd; i.wr = wr; i.rwe = rwe; i.mtr = mtr;
        return i;
    endfunction

    task automatic check_bubble(input string tag);
        check({tag, "_bubble_rwe"}, reg_write_en_w, 1'b0);
        check({tag, "_bubble_dest"}, dest_reg_w, 5'd0);
        check({tag, "_bubble_err"}, mem_err_w, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req"}, dmem_req, 1'b0);
        check({tag, "_stall"}, stall_m, 1'b0);
        check({tag, "_result_w"}, result_w, 32'd0);
        check({tag, "_dest_w"}, dest_reg_w, 5'd0);
        check({tag, "_rwe_w"}, reg_write_en_w, 1'b0);
        check({tag, "_pc_w"}, pc_w, 8'd0);
        check({tag, "_err_w"}, mem_err_w, 1'b0);
    endtask

    vec_t  vecs[7];
    ins_t  idle_ins, ins;
    int    stall_cnt;
    bit    done;

    initial begin
        idle_ins = mk(0, 0, 0, 0, 0, 0, 0, 0, 2'b00);
        // {ins, ack, rdata, result_w, rwe_w, err_w, fwd_valid, fwd_data}
        vecs[0] = '{mk(32'h1234, 0, 5, 8'h02, 8'h00, 0, 0, 1, 2'b00), 0, 32'h0, 32'h1234, 1, 0, 1, 32'h1234};
        vecs[1] = '{mk(32'h10, 0, 7, 8'h04, 8'h02, 1, 0, 1, 2'b01), 1, 32'hCAFEF00D, 32'hCAFEF00D, 1, 0, 0, 32'h10};
        vecs[2] = '{mk(32'h99, 0, 31, 8'h22, 8'h20, 0, 0, 1, 2'b10), 0, 32'h0, 32'h22, 1, 0, 1, 32'h22};
        vecs[3] = '{mk(32'hDEADBEEF, 0, 0, 8'h26, 8'h24, 0, 0, 1, 2'b11), 0, 32'h0, 32'hDEADBEEF, 1, 0, 0, 32'hDEADBEEF};
        vecs[4] = '{mk(32'h8, 32'h3, 4, 8'h2A, 8'h28, 1, 1, 1, 2'b01), 1, 32'h77, 32'h0, 0, 1, 0, 32'h8};
        vecs[5] = '{mk(32'hABC, 0, 3, 8'h2E, 8'h2C, 0, 0, 1, 2'b00), 1, 32'h5555, 32'hABC, 1, 0, 1, 32'hABC};
        vecs[6] = '{mk(32'h40, 32'h9, 6, 8'h32, 8'h30, 0, 1, 0, 2'b00), 1, 32'h0, 32'h40, 0, 0, 0, 32'h40};

        // Reset with a load pending: every output must still read zero.
        reset = 1'b0;
        drive(mk(32'h10, 32'h5, 7, 8'h4, 8'h2, 1, 0, 1, 2'b01));
        dmem_ack = 1'b0;
        dmem_rdata = 32'h0;
        repeat (2) @(posedge clk);
        #2;
        check_all_zero("reset");
        check("reset_we", dmem_we, 1'b0);
        check("reset_fwd_v", fwd_valid_m, 1'b0);
        drive(idle_ins);
        @(negedge clk);
        reset = 1'b1;
        tick();

        for (int v = 0; v < 7; v++) begin
            drive(vecs[v].ins);
            dmem_ack   = vecs[v].ack;
            dmem_rdata = vecs[v].rdata;
            #1;
            check($sformatf("vec%0d_stall", v), stall_m, 1'b0);
            check($sformatf("vec%0d_req", v), dmem_req, vecs[v].ins.rd | vecs[v].ins.wr);
            check($sformatf("vec%0d_we", v), dmem_we, vecs[v].ins.wr);
            check($sformatf("vec%0d_fwd_v", v), fwd_valid_m, vecs[v].e_fwd_v);
            check($sformatf("vec%0d_fwd_d", v), fwd_data_m, vecs[v].e_fwd_d);
            tick();
            check($sformatf("vec%0d_result_w", v), result_w, vecs[v].e_result);
            check($sformatf("vec%0d_rwe_w", v), reg_write_en_w, vecs[v].e_rwe);
            check($sformatf("vec%0d_err_w", v), mem_err_w, vecs[v].e_err);
            check($sformatf("vec%0d_dest_w", v), dest_reg_w, vecs[v].ins.dest);
            check($sformatf("vec%0d_pc_w", v), pc_w, vecs[v].ins.pc);
        end

        // Store acked on the fourth cycle: exactly three stall cycles, request held stable.
        drive(mk(32'h40, 32'h55, 6, 8'h12, 8'h10, 0, 1, 0, 2'b00));
        stall_cnt = 0;
        for (int c = 0; c <= 3; c++) begin
            dmem_ack = (c == 3);
            #1;
            check("st_req", dmem_req, 1'b1);
            check("st_we", dmem_we, 1'b1);
            check("st_addr", dmem_addr, 8'h40);
            check("st_wdata", dmem_wdata, 32'h55);
            if (stall_m) stall_cnt++;
            tick();
            if (c < 3) check_bubble("st");
        end
        check("st_stall_cycles", stall_cnt, 3);
        check("st_rwe_w", reg_write_en_w, 1'b0);
        check("st_err_w", mem_err_w, 1'b0);
        check("st_pc_w", pc_w, 8'h10);

        // Load never acked: 15 stall cycles, then abort into WB with an error.
        drive(mk(32'h24, 0, 9, 8'h16, 8'h14, 1, 0, 1, 2'b01));
        dmem_ack = 1'b0;
        stall_cnt = 0;
        done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            #1;
            if (stall_m) stall_cnt++;
            else done = 1'b1;
            tick();
        end
        check("to_aborted", done, 1'b1);
        check("to_stall_cycles", stall_cnt, TIMEOUT);
        check("to_err_w", mem_err_w, 1'b1);
        check("to_rwe_w", reg_write_en_w, 1'b0);
        drive(mk(32'h77, 0, 2, 8'h1A, 8'h18, 0, 0, 1, 2'b00));
        #1;
        check("to_idle_stall", stall_m, 1'b0);
        tick();
        check("to_next_result", result_w, 32'h77);
        check("to_next_err", mem_err_w, 1'b0);

        // Reset asserted in the middle of a wait.
        drive(mk(32'h30, 0, 8, 8'h1E, 8'h1C, 1, 0, 1, 2'b01));
        dmem_ack = 1'b0;
        #1;
        check("rw_stall_before", stall_m, 1'b1);
        tick();
        tick();
        #1;
        reset = 1'b0;
        #1;
        check_all_zero("rw");
        drive(idle_ins);
        @(negedge clk);
        reset = 1'b1;
        tick();
        drive(mk(32'h5A5A, 0, 11, 8'h42, 8'h40, 0, 0, 1, 2'b00));
        #1;
        check("rw_clean_stall", stall_m, 1'b0);
        check("rw_clean_req", dmem_req, 1'b0);
        tick();
        check("rw_clean_result", result_w, 32'h5A5A);
        check("rw_clean_dest", dest_reg_w, 5'd11);

        // Random instructions against a reference built from the handshake rules.
        for (int n = 0; n < 60; n++) begin
            int          delay, stalls;
            bit          acc, aborted;
            logic [31:0] rdata_at_done, exp_res;
            logic        exp_rwe, exp_err;
            ins.alu  = $urandom;
            ins.rd2  = $urandom;
            ins.dest = 5'($urandom_range(0, 31));
            ins.pc2  = 8'($urandom);
            ins.pc   = 8'($urandom);
            ins.rd   = ($urandom_range(0, 2) == 0);
            ins.wr   = ($urandom_range(0, 3) == 0);
            ins.rwe  = 1'($urandom);
            ins.mtr  = 2'($urandom);
            acc      = ins.rd | ins.wr;
            delay    = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 3) : $urandom_range(0, TIMEOUT + 2);
            stalls   = acc ? ((delay <= TIMEOUT) ? delay : TIMEOUT) : 0;
            aborted  = acc && (delay > TIMEOUT);
            rdata_at_done = 32'h0;
            drive(ins);
            for (int c = 0; c <= stalls; c++) begin
                dmem_ack   = acc ? (c == delay) : 1'($urandom);
                dmem_rdata = $urandom;
                if (c == stalls) rdata_at_done = dmem_rdata;
                #1;
                check("rnd_stall", stall_m, (c < stalls));
                check("rnd_req", dmem_req, acc);
                check("rnd_fwd_v", fwd_valid_m, ins.rwe && !ins.rd && ins.dest != 0);
                check("rnd_fwd_d", fwd_data_m, (ins.mtr == 2'b10) ? {24'd0, ins.pc2} : ins.alu);
                tick();
                if (c < stalls) check_bubble("rnd");
            end
            if (aborted || (ins.rd && ins.wr)) begin
                exp_res = 32'h0;
                exp_rwe = 1'b0;
                exp_err = 1'b1;
            end else begin
                exp_res = (ins.mtr == 2'b01) ? rdata_at_done :
                          (ins.mtr == 2'b10) ? {24'd0, ins.pc2} : ins.alu;
                exp_rwe = ins.rwe;
                exp_err = 1'b0;
            end
            check("rnd_result_w", result_w, exp_res);
            check("rnd_rwe_w", reg_write_en_w, exp_rwe);
            check("rnd_err_w", mem_err_w, exp_err);
            check("rnd_dest_w", dest_reg_w, ins.dest);
            check("rnd_pc_w", pc_w, ins.pc);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
